// File: rtl/parking_gate_arbiter_if.sv
// Handshake bundle between the lane password FSMs, the shared-gate arbiter and the
// barrier actuator/occupancy display.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             grant_entry;
  logic             grant_exit;
  logic             entry_done;
  logic             exit_done;
  logic             timeout;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;

  modport master (
    output entry_req, exit_req, pass_sensor,
    input  gate_open, grant_entry, grant_exit, entry_done, exit_done, timeout,
    input  occupancy, full, empty
  );

  modport slave (
    input  entry_req, exit_req, pass_sensor,
    output gate_open, grant_entry, grant_exit, entry_done, exit_done, timeout,
    output occupancy, full, empty
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter and open/pass/close sequencer for one barrier shared by the
// entry and exit lanes; also keeps the occupancy count.
module parking_gate_arbiter #(
  parameter int CAPACITY      = 8,
  parameter int CNT_W         = 4,
  parameter int OPEN_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  parking_gate_arbiter_if.slave  bus
);

  localparam int TMR_W = $clog2(OPEN_CYCLES + SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [CNT_W-1:0]   occ, occ_n;
  logic               pass_q;
  logic               last_exit, last_exit_n;
  logic               grant_entry, grant_entry_n;
  logic               grant_exit, grant_exit_n;
  logic               entry_done, entry_done_n;
  logic               exit_done, exit_done_n;
  logic               timeout, timeout_n;

  logic entry_elig;
  logic exit_elig;
  logic pass_edge;

  assign entry_elig = bus.entry_req && (occ < CNT_W'(CAPACITY));
  assign exit_elig  = bus.exit_req && (occ != '0);
  assign pass_edge  = bus.pass_sensor && !pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      occ         <= '0;
      pass_q      <= 1'b0;
      last_exit   <= 1'b1;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      entry_done  <= 1'b0;
      exit_done   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      occ         <= occ_n;
      pass_q      <= bus.pass_sensor;
      last_exit   <= last_exit_n;
      grant_entry <= grant_entry_n;
      grant_exit  <= grant_exit_n;
      entry_done  <= entry_done_n;
      exit_done   <= exit_done_n;
      timeout     <= timeout_n;
    end
  end

  always_comb begin
    state_n       = state;
    timer_n       = timer;
    occ_n         = occ;
    last_exit_n   = last_exit;
    grant_entry_n = 1'b0;
    grant_exit_n  = 1'b0;
    entry_done_n  = 1'b0;
    exit_done_n   = 1'b0;
    timeout_n     = 1'b0;

    case (state)
      IDLE: begin
        // Entry wins when it is alone or when exit had the gate last.
        if (entry_elig && (!exit_elig || last_exit)) begin
          state_n       = OPEN;
          timer_n       = '0;
          grant_entry_n = 1'b1;
          last_exit_n   = 1'b0;
        end else if (exit_elig) begin
          state_n      = OPEN;
          timer_n      = '0;
          grant_exit_n = 1'b1;
          last_exit_n  = 1'b1;
        end
      end

      OPEN: begin
        if (pass_edge) begin
          // A pass on the expiry cycle still counts as a car through.
          state_n = CLOSING;
          timer_n = '0;
          if (grant_entry) begin
            occ_n        = occ + CNT_W'(1);
            entry_done_n = 1'b1;
          end else begin
            occ_n       = occ - CNT_W'(1);
            exit_done_n = 1'b1;
          end
        end else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
          state_n   = CLOSING;
          timer_n   = '0;
          timeout_n = 1'b1;
        end else begin
          timer_n       = timer + TMR_W'(1);
          grant_entry_n = grant_entry;
          grant_exit_n  = grant_exit;
        end
      end

      CLOSING: begin
        if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign bus.gate_open   = grant_entry | grant_exit;
  assign bus.grant_entry = grant_entry;
  assign bus.grant_exit  = grant_exit;
  assign bus.entry_done  = entry_done;
  assign bus.exit_done   = exit_done;
  assign bus.timeout     = timeout;
  assign bus.occupancy   = occ;
  assign bus.full        = (occ == CNT_W'(CAPACITY));
  assign bus.empty       = (occ == '0);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: grant timing, round-robin, full/empty
// refusal, timeout versus pass, stale sensor level and asynchronous reset.
module tb_parking_gate_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAPACITY(8), .CNT_W(4), .OPEN_CYCLES(16), .SETTLE_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Car crosses on the next edge; returns 1ns after that edge.
  task automatic pass_car();
    bus.pass_sensor = 1'b1;
    tick();
    bus.pass_sensor = 1'b0;
  endtask

  task automatic settle();
    tick(2);
  endtask

  task automatic test_reset();
    bus.entry_req   = 1'b0;
    bus.exit_req    = 1'b0;
    bus.pass_sensor = 1'b0;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({bus.gate_open, bus.grant_entry, bus.grant_exit, bus.entry_done, bus.exit_done, bus.timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.gate_open, bus.grant_entry, bus.grant_exit, bus.entry_done, bus.exit_done, bus.timeout});
    end
    checks++;
    if (bus.occupancy !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_occ: occ=%0d empty=%b full=%b want 0 1 0", bus.occupancy, bus.empty, bus.full);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_entry();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    checks++;
    if (bus.grant_entry !== 1'b1 || bus.gate_open !== 1'b1 || bus.grant_exit !== 1'b0) begin
      errors++;
      $display("FAIL entry_grant: ge=%b gx=%b open=%b want 1 0 1", bus.grant_entry, bus.grant_exit, bus.gate_open);
    end
    tick(2);
    pass_car();
    checks++;
    if (bus.entry_done !== 1'b1 || bus.occupancy !== 4'd1 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL entry_pass: done=%b occ=%0d open=%b want 1 1 0", bus.entry_done, bus.occupancy, bus.gate_open);
    end
    bus.entry_req = 1'b1;
    tick();
    checks++;
    if (bus.entry_done !== 1'b0 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL settle_1: done=%b open=%b want 0 0", bus.entry_done, bus.gate_open);
    end
    tick();
    checks++;
    if (bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL settle_2: open=%b want 0", bus.gate_open);
    end
    tick();
    checks++;
    if (bus.grant_entry !== 1'b1 || bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL regrant: ge=%b open=%b want 1 1", bus.grant_entry, bus.gate_open);
    end
    bus.entry_req = 1'b0;
    pass_car();
    checks++;
    if (bus.occupancy !== 4'd2) begin
      errors++;
      $display("FAIL occ_after_two: got %0d want 2", bus.occupancy);
    end
    settle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_occ [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    logic       exp_ent [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.grant_entry !== exp_ent[k] || bus.grant_exit !== !exp_ent[k]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ge=%b gx=%b want %b %b", k, bus.grant_entry, bus.grant_exit, exp_ent[k], !exp_ent[k]);
      end
      pass_car();
      checks++;
      if (bus.occupancy !== exp_occ[k] || bus.entry_done !== exp_ent[k] || bus.exit_done !== !exp_ent[k]) begin
        errors++;
        $display("FAIL rr_pass[%0d]: occ=%0d ed=%b xd=%b want %0d %b %b", k, bus.occupancy,
                 bus.entry_done, bus.exit_done, exp_occ[k], exp_ent[k], !exp_ent[k]);
      end
      settle();
    end
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
  endtask

  task automatic test_full();
    for (int k = 0; k < 6; k++) begin
      bus.entry_req = 1'b1;
      tick();
      bus.entry_req = 1'b0;
      pass_car();
      settle();
    end
    checks++;
    if (bus.occupancy !== 4'd8 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL filled: occ=%0d full=%b want 8 1", bus.occupancy, bus.full);
    end
    bus.entry_req = 1'b1;
    tick(3);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.grant_entry !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse: open=%b ge=%b want 0 0", bus.gate_open, bus.grant_entry);
    end
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req = 1'b0;
    checks++;
    if (bus.grant_exit !== 1'b1 || bus.grant_entry !== 1'b0) begin
      errors++;
      $display("FAIL full_exit_grant: gx=%b ge=%b want 1 0", bus.grant_exit, bus.grant_entry);
    end
    pass_car();
    checks++;
    if (bus.exit_done !== 1'b1 || bus.occupancy !== 4'd7 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL full_exit_pass: xd=%b occ=%0d full=%b want 1 7 0", bus.exit_done, bus.occupancy, bus.full);
    end
    settle();
    tick();
    checks++;
    if (bus.grant_entry !== 1'b1) begin
      errors++;
      $display("FAIL entry_after_exit: ge=%b want 1", bus.grant_entry);
    end
    bus.entry_req = 1'b0;
    pass_car();
    settle();
  endtask

  task automatic test_empty();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.exit_req = 1'b1;
    tick(4);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.grant_exit !== 1'b0 || bus.empty !== 1'b1 || bus.occupancy !== 4'd0) begin
      errors++;
      $display("FAIL empty_refuse: open=%b gx=%b empty=%b occ=%0d want 0 0 1 0",
               bus.gate_open, bus.grant_exit, bus.empty, bus.occupancy);
    end
    bus.exit_req = 1'b0;
  endtask

  task automatic test_timeout();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    tick(15);
    checks++;
    if (bus.timeout !== 1'b0 || bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL pre_timeout: to=%b open=%b want 0 1", bus.timeout, bus.gate_open);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b1 || bus.gate_open !== 1'b0 || bus.occupancy !== 4'd0 || bus.entry_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout: to=%b open=%b occ=%0d ed=%b want 1 0 0 0",
               bus.timeout, bus.gate_open, bus.occupancy, bus.entry_done);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b want 0", bus.timeout);
    end
    tick();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    tick(15);
    pass_car();
    checks++;
    if (bus.entry_done !== 1'b1 || bus.timeout !== 1'b0 || bus.occupancy !== 4'd1) begin
      errors++;
      $display("FAIL pass_at_expiry: ed=%b to=%b occ=%0d want 1 0 1", bus.entry_done, bus.timeout, bus.occupancy);
    end
    settle();
  endtask

  task automatic test_stale_pass();
    bus.pass_sensor = 1'b1;
    tick();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    tick(3);
    checks++;
    if (bus.gate_open !== 1'b1 || bus.entry_done !== 1'b0 || bus.occupancy !== 4'd1) begin
      errors++;
      $display("FAIL stale_pass: open=%b ed=%b occ=%0d want 1 0 1", bus.gate_open, bus.entry_done, bus.occupancy);
    end
    bus.pass_sensor = 1'b0;
    tick();
    pass_car();
    checks++;
    if (bus.entry_done !== 1'b1 || bus.occupancy !== 4'd2) begin
      errors++;
      $display("FAIL fresh_pass: ed=%b occ=%0d want 1 2", bus.entry_done, bus.occupancy);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.entry_req = 1'b1;
      tick();
      bus.entry_req = 1'b0;
      pass_car();
      settle();
    end
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    checks++;
    if (bus.gate_open !== 1'b1 || bus.occupancy !== 4'd5) begin
      errors++;
      $display("FAIL before_rst: open=%b occ=%0d want 1 5", bus.gate_open, bus.occupancy);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gate_open !== 1'b0 || bus.grant_entry !== 1'b0 || bus.occupancy !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: open=%b ge=%b occ=%0d empty=%b want 0 0 0 1",
               bus.gate_open, bus.grant_entry, bus.occupancy, bus.empty);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_rst: open=%b want 0", bus.gate_open);
    end
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    checks++;
    if (bus.grant_entry !== 1'b1 || bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL grant_after_rst: ge=%b open=%b want 1 1", bus.grant_entry, bus.gate_open);
    end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_round_robin();
    test_full();
    test_empty();
    test_timeout();
    test_stale_pass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
